axil_mem_master: RTL

- Bridges the CPU's simple single-outstanding memory request port to an AXI4-Lite master interface.
- Sits directly upstream of the AXI4-Lite RAM; its m_axil_* ports connect 1:1 to the RAM slave ports.
- Serialises one read or one write at a time.
- Returns read data, a one-cycle completion pulse and an error flag derived from BRESP/RRESP.

---
 rtl/mem_defines_pkg.sv | 30 +++
 rtl/axil_mem_master.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_defines_pkg.sv
// ============================================================================
// Module : mem_defines
// Brief  : Shared AXI4-Lite response codes, master FSM states, protection values
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_defines;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } axil_mst_state_t;

  localparam logic [2:0] AXIL_PROT_INSTR = 3'b100;
  localparam logic [2:0] AXIL_PROT_DATA  = 3'b000;

endpackage

`default_nettype wire

// File: rtl/axil_mem_master.sv
// ============================================================================
// Module : axil_mem_master
// Brief  : CPU single-outstanding memory port to AXI4-Lite master bridge
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axil_mem_master
  import mem_defines::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic                  mem_instr,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [STRB_WIDTH-1:0] mem_be,
  output logic                  mem_gnt,
  output logic                  mem_done,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_err,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  axil_mst_state_t         r_state;
  axil_mst_state_t         w_next_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_WIDTH-1:0]   r_be;
  logic                    r_instr;
  logic                    r_aw_done;
  logic                    r_w_done;
  logic                    r_done;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    w_aw_fire;
  logic                    w_w_fire;

  assign mem_gnt   = (r_state == IDLE) && mem_req && !rst;
  assign w_aw_fire = m_axil_awvalid && m_axil_awready;
  assign w_w_fire  = m_axil_wvalid && m_axil_wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (mem_gnt) begin
          w_next_state = mem_we ? WR : RD_ADDR;
        end
      end
      // AW and W complete independently; leave once both have, in either order
      WR: begin
        if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
          w_next_state = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axil_bvalid) begin
          w_next_state = IDLE;
        end
      end
      RD_ADDR: begin
        if (m_axil_arready) begin
          w_next_state = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axil_rvalid) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Valids and readies decode from registered state only, so they are glitch-free
  always_comb begin
    m_axil_awvalid = 1'b0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    m_axil_arvalid = 1'b0;
    m_axil_rready  = 1'b0;
    case (r_state)
      WR: begin
        m_axil_awvalid = !r_aw_done;
        m_axil_wvalid  = !r_w_done;
      end
      WR_RESP: m_axil_bready  = 1'b1;
      RD_ADDR: m_axil_arvalid = 1'b1;
      RD_DATA: m_axil_rready  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_instr   <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (mem_gnt) begin
        r_addr  <= mem_addr;
        r_wdata <= mem_wdata;
        r_be    <= mem_be;
        r_instr <= mem_instr;
      end
      if (r_state != WR) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_fire) r_aw_done <= 1'b1;
        if (w_w_fire)  r_w_done  <= 1'b1;
      end
      if ((r_state == WR_RESP) && m_axil_bvalid) begin
        r_done <= 1'b1;
        r_err  <= (m_axil_bresp != OKAY);
      end
      if ((r_state == RD_DATA) && m_axil_rvalid) begin
        r_done  <= 1'b1;
        r_err   <= (m_axil_rresp != OKAY);
        r_rdata <= m_axil_rdata;
      end
    end
  end

  assign mem_done      = r_done;
  assign mem_err       = r_err;
  assign mem_rdata     = r_rdata;
  assign m_axil_awaddr = r_addr;
  assign m_axil_awprot = AXIL_PROT_DATA;
  assign m_axil_wdata  = r_wdata;
  assign m_axil_wstrb  = r_be;
  assign m_axil_araddr = r_addr;
  assign m_axil_arprot = r_instr ? AXIL_PROT_INSTR : AXIL_PROT_DATA;

endmodule

`default_nettype wire
